vector_alu_seq: RTL and testbench
=================================

Name: vector_alu_seq

Overview:
- Sequential, parametrised successor to the combinational lane ALU (aluMain).
- Executes ADD/SUB/MOV/MUL/DIV on LANES unsigned WIDTH-bit lanes.
- Adds a valid/ready handshake on input and output, a per-lane write mask, and an optional saturating mode.
- DIV becomes an iterative multi-cycle operation.
- Sits between the vector register-file read stage and writeback in the vector processor pipeline.

Parameters:
- WIDTH, 20, bits per lane (>=2).
- LANES, 8, number of parallel lanes (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- A  in  [LANES-1:0][WIDTH-1:0]  operand A vector.
- B  in  [LANES-1:0][WIDTH-1:0]  operand B vector.
- Operation  in  3  000 ADD, 001 SUB, 010 MOV, 011 MUL, 100 DIV, 101-111 illegal.
- sat  in  1  1 = saturating ADD/SUB/MUL.
- mask  in  LANES  1 = lane active; 0 = lane passes A through unchanged.
- out_valid  out  1  Result valid.
- out_ready  in  1  consumer accepts Result.
- Result  out  [LANES-1:0][WIDTH-1:0]  registered result vector.
- ovf  out  LANES  per-lane overflow/saturation event.
- dz  out  LANES  per-lane divide-by-zero.
- err  out  1  illegal Operation accepted.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - out_valid, Result, ovf, dz and err all go to 0.
  - in_ready is held 0 while reset is asserted.
  - Any in-flight DIV is aborted with no output.
- FSM states: IDLE, BUSY (divide in progress), HOLD (Result valid, waiting for the consumer).
- Handshake:
  - Transfer occurs when in_valid & in_ready.
  - in_ready = (state==IDLE) | (state==HOLD & out_ready).
  - Output transfer occurs when out_valid & out_ready.
  - Result, ovf, dz and err are stable while out_valid=1 & out_ready=0.
- Transitions:
  - IDLE, accept non-DIV -> HOLD. Result is registered, so out_valid rises the next cycle (latency 1).
  - IDLE, accept DIV -> BUSY. Operands are latched and a WIDTH-cycle divide starts.
  - BUSY -> HOLD after WIDTH cycles. out_valid is asserted at accept+WIDTH+1 (21 cycles at WIDTH=20). in_ready=0 throughout BUSY.
  - HOLD, out_ready=1 with no new accept -> IDLE, out_valid drops.
  - HOLD, out_ready=1 with a simultaneous accept -> back-to-back operation. A non-DIV stays in HOLD with the new Result the next cycle; a DIV goes to BUSY.
  - HOLD, out_ready=0 -> remain in HOLD; inputs are ignored.
- Arithmetic, per active lane, unsigned:
  - ADD:
    - sat=0: wraps modulo 2^WIDTH; ovf=carry-out.
    - sat=1: clamps to 2^WIDTH-1; ovf=1 when clamped.
  - SUB:
    - sat=0: wraps; ovf=borrow.
    - sat=1: clamps to 0; ovf=1 when clamped.
  - MOV: Result=A; ovf=0.
  - MUL:
    - sat=0: full 2*WIDTH product truncated to the low WIDTH bits; ovf=(high half != 0).
    - sat=1: clamps to 2^WIDTH-1 when the high half != 0; ovf=1 when clamped.
  - DIV:
    - Quotient floor(A/B); ovf=0.
    - B=0 gives quotient all ones and dz=1.
- Masked lanes (mask[i]=0): Result[i]=A[i]; ovf[i]=0; dz[i]=0. This applies to DIV as well.
- Illegal op: Result=0 on all lanes; err=1; completes with latency 1.
- Outputs update only at completion; ovf, dz and err describe the current Result.

Decomposition:
- Package vector_alu_pkg:
  - op_t enum: OP_ADD, OP_SUB, OP_MOV, OP_MUL, OP_DIV.
  - state_t enum: IDLE, BUSY, HOLD.
  - Constant DIV_CYCLES=WIDTH.
- Sub-module lane_divider, one instance per lane:
  - Restoring divider, one bit per cycle.
  - Ports: clk, reset, start, dividend, divisor, quotient, done, dz.
  - Driven by a shared iteration counter in the parent.

Test Plan:
- ADD, sat=0, mask=FF: A={100,254,251,200,5,10,100,15}, B={100,1,1,45,25,1,2,10} -> out_valid one cycle after accept; Result={200,255,252,245,30,11,102,25}; ovf=0.
- ADD at the boundary: A[0]=1048575, B[0]=1. sat=0 -> Result[0]=0, ovf[0]=1. sat=1 -> Result[0]=1048575, ovf[0]=1.
- SUB, sat=1: A[1]=5, B[1]=9 -> Result[1]=0, ovf[1]=1. MUL, sat=0: A[2]=2048, B[2]=1024 -> Result[2]=0, ovf[2]=1.
- DIV: A={2,6,10,15,200,8,25,50}, B={2,2,2,2,100,4,5,0}:
  - in_ready=0 for 20 cycles; out_valid at accept+21.
  - Result={1,3,5,7,2,2,5,1048575}; dz=8'h80.
- mask=8'h0F on MUL with A[7]=50 -> Result[7]=50; lanes 0-3 computed.
- Backpressure: hold out_ready=0 for 5 cycles -> Result stable and in_ready=0. Then out_ready=1 with an ADD presented -> it is accepted the same cycle and the new Result appears the next cycle.
- Assert reset mid-DIV at cycle 10 -> out_valid stays 0; after release, in_ready=1 and a fresh MOV completes normally.

Source files
------------

// File: rtl/vector_alu_pkg.sv
// Shared types and constants for the sequential vector lane ALU.
package vector_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MOV = 3'b010,
    OP_MUL = 3'b011,
    OP_DIV = 3'b100
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One quotient bit is produced per cycle.
  function automatic int unsigned div_cycles(input int unsigned width);
    return width;
  endfunction

endpackage

// File: rtl/vector_alu_seq_lane_divider.sv
// Restoring unsigned divider for one lane, one quotient bit per step.
module lane_divider #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic             done,
  output logic             dz
);

  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             dz_q;
  logic [WIDTH:0]   shifted, trial;
  logic             ge;
  logic [WIDTH-1:0] rem_n, quo_n;

  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_n   = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_n   = {quo_q[WIDTH-2:0], ge};
  end

  // Quotient is presented combinationally so the parent can capture it on the final step.
  assign quotient = quo_n;
  assign done     = step & last;
  assign dz       = dz_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dz_q  <= 1'b0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      dz_q  <= (divisor == '0);
    end else if (step) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
    end
  end

endmodule

// File: rtl/vector_alu_seq.sv
// Sequential masked vector lane ALU with valid/ready handshake and iterative divide.
module vector_alu_seq
  import vector_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned LANES = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]  A,
  input  logic [LANES-1:0][WIDTH-1:0]  B,
  input  logic [2:0]                   Operation,
  input  logic                         sat,
  input  logic [LANES-1:0]             mask,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES-1:0][WIDTH-1:0]  Result,
  output logic [LANES-1:0]             ovf,
  output logic [LANES-1:0]             dz,
  output logic                         err
);

  localparam int unsigned DIV_CYCLES = div_cycles(WIDTH);
  localparam int unsigned CW         = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [LANES-1:0][WIDTH-1:0]  res_q, res_d, a_q, a_d;
  logic [LANES-1:0]             ovf_q, ovf_d, dz_q, dz_d, mask_q, mask_d;
  logic                         err_q, err_d;

  logic [LANES-1:0][WIDTH-1:0]  alu_res, div_quo;
  logic [LANES-1:0]             alu_ovf, div_dz, div_done;
  logic                         alu_err, accept, is_div;
  logic                         div_start, div_step, div_last;

  assign in_ready  = reset & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign accept    = in_valid & in_ready;
  assign is_div    = (Operation == OP_DIV);
  assign out_valid = (state_q == HOLD);
  assign Result    = res_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;
  assign err       = err_q;

  // Single-cycle lane arithmetic for everything except DIV.
  always_comb begin
    alu_res = '0;
    alu_ovf = '0;
    alu_err = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      logic [WIDTH:0]     sum, diff;
      logic [2*WIDTH-1:0] prod;
      sum  = {1'b0, A[i]} + {1'b0, B[i]};
      diff = {1'b0, A[i]} - {1'b0, B[i]};
      prod = {{WIDTH{1'b0}}, A[i]} * {{WIDTH{1'b0}}, B[i]};
      case (Operation)
        OP_ADD: begin
          alu_ovf[i] = sum[WIDTH];
          alu_res[i] = (sat && sum[WIDTH]) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
        end
        OP_SUB: begin
          alu_ovf[i] = diff[WIDTH];
          alu_res[i] = (sat && diff[WIDTH]) ? '0 : diff[WIDTH-1:0];
        end
        OP_MOV: alu_res[i] = A[i];
        OP_MUL: begin
          alu_ovf[i] = |prod[2*WIDTH-1:WIDTH];
          alu_res[i] = (sat && alu_ovf[i]) ? {WIDTH{1'b1}} : prod[WIDTH-1:0];
        end
        default: alu_err = 1'b1;
      endcase
      if (!mask[i]) begin
        alu_res[i] = A[i];
        alu_ovf[i] = 1'b0;
      end
    end
    // Illegal opcodes zero every lane regardless of mask.
    if (alu_err) begin
      alu_res = '0;
      alu_ovf = '0;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_div
    lane_divider #(
      .WIDTH (WIDTH)
    ) u_div (
      .clk      (clk),
      .reset    (reset),
      .start    (div_start),
      .step     (div_step),
      .last     (div_last),
      .dividend (A[g]),
      .divisor  (B[g]),
      .quotient (div_quo[g]),
      .done     (div_done[g]),
      .dz       (div_dz[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;
    err_d     = err_q;
    a_d       = a_q;
    mask_d    = mask_q;
    div_start = 1'b0;
    div_step  = 1'b0;
    div_last  = 1'b0;
    unique case (state_q)
      IDLE, HOLD: begin
        if (state_q == HOLD && out_ready) state_d = IDLE;
        if (accept) begin
          if (is_div) begin
            state_d   = BUSY;
            cnt_d     = '0;
            div_start = 1'b1;
            a_d       = A;
            mask_d    = mask;
          end else begin
            state_d = HOLD;
            res_d   = alu_res;
            ovf_d   = alu_ovf;
            dz_d    = '0;
            err_d   = alu_err;
          end
        end
      end
      BUSY: begin
        div_step = 1'b1;
        div_last = (cnt_q == CW'(DIV_CYCLES - 1));
        cnt_d    = cnt_q + 1'b1;
        if (&div_done) begin
          state_d = HOLD;
          for (int i = 0; i < LANES; i++) begin
            res_d[i] = mask_q[i] ? div_quo[i] : a_q[i];
          end
          ovf_d = '0;
          dz_d  = div_dz & mask_q;
          err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      ovf_q   <= '0;
      dz_q    <= '0;
      err_q   <= 1'b0;
      a_q     <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
      err_q   <= err_d;
      a_q     <= a_d;
      mask_q  <= mask_d;
    end
  end

endmodule

// File: tb/tb_vector_alu_seq.sv
// Directed bench for vector_alu_seq: a transaction-level model checked every cycle plus literal pins.
module tb_vector_alu_seq;

  localparam int unsigned WIDTH = 20;
  localparam int unsigned LANES = 8;

  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;
  typedef struct {
    vec_t             res;
    logic [LANES-1:0] ovf;
    logic [LANES-1:0] dz;
    logic             err;
    int               due;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset, in_valid, in_ready, sat, out_valid, out_ready, err;
  vec_t             A, B, Result;
  logic [2:0]       Operation;
  logic [LANES-1:0] mask, ovf, dz;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  vector_alu_seq #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Operation (Operation),
    .sat       (sat),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .ovf       (ovf),
    .dz        (dz),
    .err       (err)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int unsigned v0, v1, v2, v3, v4, v5, v6, v7);
    vec_t v;
    v[0] = WIDTH'(v0); v[1] = WIDTH'(v1); v[2] = WIDTH'(v2); v[3] = WIDTH'(v3);
    v[4] = WIDTH'(v4); v[5] = WIDTH'(v5); v[6] = WIDTH'(v6); v[7] = WIDTH'(v7);
    return v;
  endfunction

  // Expected completion computed with plain integer arithmetic.
  function automatic exp_t model(input vec_t a, input vec_t b, input logic [2:0] op,
                                 input logic s, input logic [LANES-1:0] m);
    exp_t e;
    longint unsigned av, bv, r, lim;
    lim   = 64'd1 << WIDTH;
    e.res = '0;
    e.ovf = '0;
    e.dz  = '0;
    e.err = (op > 3'd4);
    e.due = 0;
    for (int i = 0; i < LANES; i++) begin
      av = a[i];
      bv = b[i];
      r  = 0;
      case (op)
        3'd0: begin
          r = av + bv;
          if (r >= lim) begin e.ovf[i] = 1'b1; r = s ? lim - 1 : r - lim; end
        end
        3'd1: begin
          if (av < bv) begin e.ovf[i] = 1'b1; r = s ? 0 : av + lim - bv; end
          else r = av - bv;
        end
        3'd2: r = av;
        3'd3: begin
          r = av * bv;
          if (r >= lim) begin e.ovf[i] = 1'b1; r = s ? lim - 1 : r % lim; end
        end
        3'd4: begin
          if (bv == 0) begin r = lim - 1; e.dz[i] = 1'b1; end
          else r = av / bv;
        end
        default: r = 0;
      endcase
      if (!e.err && !m[i]) begin
        r         = av;
        e.ovf[i]  = 1'b0;
        e.dz[i]   = 1'b0;
      end
      e.res[i] = r[WIDTH-1:0];
    end
    return e;
  endfunction

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit   exp_valid, exp_ready;
    exp_t e;
    if (!reset) begin
      q.delete();
      chk("reset_in_ready", in_ready, 0);
      chk("reset_out_valid", out_valid, 0);
    end else begin
      exp_valid = (q.size() > 0) && (cyc >= q[0].due);
      exp_ready = (q.size() == 0) || (exp_valid && out_ready);
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, exp_ready);
      if (exp_valid) begin
        chk("Result", Result, q[0].res);
        chk("ovf", ovf, q[0].ovf);
        chk("dz", dz, q[0].dz);
        chk("err", err, q[0].err);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && exp_ready) begin
        e     = model(A, B, Operation, sat, mask);
        e.due = cyc + ((Operation == 3'd4) ? WIDTH + 1 : 1);
        q.push_back(e);
      end
    end
    cyc++;
  end

  task automatic issue(input logic [2:0] op, input logic s, input logic [LANES-1:0] m,
                       input vec_t a, input vec_t b);
    bit ok = 0;
    @(posedge clk);
    #1;
    Operation = op; sat = s; mask = m; A = a; B = b; in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (out_valid) begin n = k; return; end
    end
    chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    int   n, busy_lo, seen;
    vec_t z;
    z = '0;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sat = 1'b0; mask = '1;
    A = '0; B = '0; Operation = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_Result", Result, 0);
    chk("rst_flags", {ovf, dz, err}, 0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Plain ADD
    issue(3'd0, 0, 8'hFF, mk(100, 254, 251, 200, 5, 10, 100, 15), mk(100, 1, 1, 45, 25, 1, 2, 10));
    wait_out(n);
    chk("add_latency", n, 1);
    chk("add_Result", Result, mk(200, 255, 252, 245, 30, 11, 102, 25));
    chk("add_ovf", ovf, 0);

    // ADD boundary, wrap then saturate
    issue(3'd0, 0, 8'hFF, mk(1048575, 0, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0, 0));
    wait_out(n);
    chk("addwrap_r0", Result[0], 0);
    chk("addwrap_ovf", ovf, 8'h01);
    issue(3'd0, 1, 8'hFF, mk(1048575, 0, 0, 0, 0, 0, 0, 0), mk(1, 0, 0, 0, 0, 0, 0, 0));
    wait_out(n);
    chk("addsat_r0", Result[0], 1048575);
    chk("addsat_ovf", ovf, 8'h01);

    // SUB saturating, MUL wrapping
    issue(3'd1, 1, 8'hFF, mk(0, 5, 0, 0, 0, 0, 0, 0), mk(0, 9, 0, 0, 0, 0, 0, 0));
    wait_out(n);
    chk("subsat_r1", Result[1], 0);
    chk("subsat_ovf", ovf, 8'h02);
    issue(3'd3, 0, 8'hFF, mk(0, 0, 2048, 0, 0, 0, 0, 0), mk(0, 0, 1024, 0, 0, 0, 0, 0));
    wait_out(n);
    chk("mul_r2", Result[2], 0);
    chk("mul_ovf", ovf, 8'h04);

    // DIV with a zero divisor in lane 7
    issue(3'd4, 0, 8'hFF, mk(2, 6, 10, 15, 200, 8, 25, 50), mk(2, 2, 2, 2, 100, 4, 5, 0));
    busy_lo = 0;
    n = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (out_valid) begin n = k; break; end
      if (!in_ready) busy_lo++;
    end
    chk("div_latency", n, 21);
    chk("div_busy_cycles", busy_lo, 20);
    chk("div_Result", Result, mk(1, 3, 5, 7, 2, 2, 5, 1048575));
    chk("div_dz", dz, 8'h80);

    // Masked MUL
    issue(3'd3, 0, 8'h0F, mk(3, 4, 5, 6, 7, 8, 9, 50), mk(4, 5, 6, 7, 2, 2, 2, 2));
    wait_out(n);
    chk("mask_Result", Result, mk(12, 20, 30, 42, 7, 8, 9, 50));

    // Illegal opcode
    issue(3'd6, 0, 8'h0F, mk(1, 2, 3, 4, 5, 6, 7, 8), mk(1, 1, 1, 1, 1, 1, 1, 1));
    wait_out(n);
    chk("ill_Result", Result, 0);
    chk("ill_err", err, 1);

    // Backpressure then back-to-back accept
    @(posedge clk);
    #1 out_ready = 1'b0;
    issue(3'd0, 0, 8'hFF, mk(1, 2, 3, 4, 5, 6, 7, 8), mk(10, 10, 10, 10, 10, 10, 10, 10));
    wait_out(n);
    @(posedge clk);
    #1;
    Operation = 3'd0; sat = 0; mask = 8'hFF; in_valid = 1'b1;
    A = mk(7, 7, 7, 7, 7, 7, 7, 7); B = mk(0, 1, 2, 3, 4, 5, 6, 7);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_Result", Result, mk(11, 12, 13, 14, 15, 16, 17, 18));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", out_valid, 1);
    chk("b2b_Result", Result, mk(7, 8, 9, 10, 11, 12, 13, 14));

    // Reset in the middle of a divide
    issue(3'd4, 0, 8'hFF, mk(9, 9, 9, 9, 9, 9, 9, 9), mk(3, 3, 3, 3, 3, 3, 3, 3));
    repeat (9) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    chk("abort_in_ready", in_ready, 1);
    issue(3'd2, 0, 8'hFF, mk(1, 2, 3, 4, 5, 6, 7, 8), mk(8, 7, 6, 5, 4, 3, 2, 1));
    wait_out(n);
    chk("mov_latency", n, 1);
    chk("mov_Result", Result, mk(1, 2, 3, 4, 5, 6, 7, 8));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
